// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the fetch stage and its bus interface.
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the bubble loaded into IF/ID when no instruction is ready
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM: REQ = request pending, WAIT = granted and awaiting data,
  // FULL = output buffer holds an instruction.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage and imem.
interface ifetch_unit_if;
  import rv32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_unit.sv
// RV32I instruction-fetch stage: issues sequential word fetches over the
// req/gnt/rvalid bus, keeps the returned word in a one-entry buffer that is
// presented to the IF/ID register, and handles IF/ID stalls and redirects.
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  ifetch_unit_if.master    imem,
  input  logic             IF_IDWrite,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             IF_Valid,
  output logic [XLEN-1:0]  IF_PC,
  output logic [XLEN-1:0]  IF_PCplus4,
  output logic [XLEN-1:0]  IF_Instr
);

  fetch_state_e    r_state,     w_state_nxt;
  logic [XLEN-1:0] r_pc,        w_pc_nxt;
  logic [XLEN-1:0] r_req_pc,    w_req_pc_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic [XLEN-1:0] r_out_pc,    w_out_pc_nxt;
  logic [XLEN-1:0] r_out_instr, w_out_instr_nxt;
  logic            r_kill,      w_kill_nxt;

  logic            w_req;
  logic [XLEN-1:0] w_redirect_tgt;

  // Redirect targets are forced to a word boundary; the low bits are ignored.
  assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;

  // A request goes out when nothing is in flight, or when the buffer is being
  // drained this cycle; never during a redirect cycle.
  assign w_req = ((r_state == REQ) || ((r_state == FULL) && IF_IDWrite)) && !redirect;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  // State, PC and output buffer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_kill      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_kill      <= w_kill_nxt;
    end
  end

  // Next-state logic: redirect first, then the per-state fetch protocol.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_instr_nxt = r_out_instr;
    w_kill_nxt      = r_kill;

    if (redirect) begin
      w_pc_nxt        = w_redirect_tgt;
      w_out_valid_nxt = 1'b0;
      unique case (r_state)
        WAIT: begin
          if (imem.imem_rvalid) begin
            // The in-flight word arrives now and is simply discarded, so no
            // stale response remains to be filtered later.
            w_kill_nxt  = 1'b0;
            w_state_nxt = REQ;
          end else begin
            // The in-flight word is for the old path; mark it for dropping.
            w_kill_nxt  = 1'b1;
            w_state_nxt = WAIT;
          end
        end
        default: w_state_nxt = REQ;
      endcase
    end else begin
      unique case (r_state)
        REQ: begin
          if (imem.imem_gnt) begin
            w_req_pc_nxt = r_pc;
            w_state_nxt  = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = REQ;
            end else begin
              w_out_instr_nxt = imem.imem_rdata;
              w_out_pc_nxt    = r_req_pc;
              w_out_valid_nxt = 1'b1;
              w_pc_nxt        = r_req_pc + 32'd4;
              w_state_nxt     = FULL;
            end
          end
        end
        FULL: begin
          // IF/ID takes the buffer; the next fetch may be granted in the
          // same cycle, otherwise it is retried from REQ.
          if (IF_IDWrite) begin
            w_out_valid_nxt = 1'b0;
            if (imem.imem_gnt) begin
              w_req_pc_nxt = r_pc;
              w_state_nxt  = WAIT;
            end else begin
              w_state_nxt = REQ;
            end
          end
        end
        default: w_state_nxt = REQ;
      endcase
    end
  end

  // Present the buffer, or a NOP bubble with zeroed PCs when it is empty.
  always_comb begin
    IF_Valid   = 1'b0;
    IF_PC      = '0;
    IF_PCplus4 = '0;
    IF_Instr   = NOP_INSTR;
    if (r_out_valid) begin
      IF_Valid   = 1'b1;
      IF_PC      = r_out_pc;
      IF_PCplus4 = r_out_pc + 32'd4;
      IF_Instr   = r_out_instr;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed table, hand-written corner sequences and
// a randomized run against a stream-level model of the fetched program order.
module tb_ifetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IF_IDWrite;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        IF_Valid;
  logic [31:0] IF_PC, IF_PCplus4, IF_Instr;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (bus),
    .IF_IDWrite  (IF_IDWrite),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IF_Valid    (IF_Valid),
    .IF_PC       (IF_PC),
    .IF_PCplus4  (IF_PCplus4),
    .IF_Instr    (IF_Instr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model: at most one outstanding access, answered lat cycles later.
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt  = 0;
  int          lat    = 1;
  bit          s_grant = 1'b0;
  bit          s_rv    = 1'b0;
  logic [31:0] s_addr  = '0;

  // Program-order model: the PC the pipeline must receive next.
  logic [31:0] exp_pc    = '0;
  int          consumed  = 0;
  bit          hold_last = 1'b0;
  logic [31:0] hold_addr = '0;
  bit          redir_last = 1'b0;

  typedef struct {
    logic        idw;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Invariants and stream model, evaluated at the falling edge.
  task automatic monitor();
    if (!reset_n) begin
      exp_pc     = 32'h0;
      hold_last  = 1'b0;
      redir_last = 1'b0;
      s_grant    = 1'b0;
      s_rv       = 1'b0;
      return;
    end
    s_grant = bus.imem_req && bus.imem_gnt;
    s_rv    = bus.imem_rvalid;
    s_addr  = bus.imem_addr;
    if (bus.imem_req) chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'h0);
    if (redirect) chk("req_in_redirect", {31'b0, bus.imem_req}, 32'h0);
    if (redir_last) chk("valid_after_redirect", {31'b0, IF_Valid}, 32'h0);
    if (hold_last && !redirect) begin
      chk("req_held", {31'b0, bus.imem_req}, 32'h1);
      chk("addr_held", bus.imem_addr, hold_addr);
    end
    if (IF_Valid) begin
      chk("instr_data", IF_Instr, IF_PC ^ KEY);
      chk("pcplus4", IF_PCplus4, IF_PC + 32'd4);
    end else begin
      chk("bubble_pc", IF_PC, 32'h0);
      chk("bubble_pcplus4", IF_PCplus4, 32'h0);
      chk("bubble_instr", IF_Instr, NOP_INSTR);
    end
    if (redirect) begin
      exp_pc = redirect_pc & ~32'h3;
    end else if (IF_Valid && IF_IDWrite) begin
      chk("stream_pc", IF_PC, exp_pc);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    hold_last  = bus.imem_req && !bus.imem_gnt;
    hold_addr  = bus.imem_addr;
    redir_last = redirect;
  endtask

  task automatic mem_step();
    if (!reset_n) begin
      m_pend = 1'b0;
    end else begin
      if (s_rv) m_pend = 1'b0;
      if (s_grant) begin
        m_pend = 1'b1;
        m_addr = s_addr;
        m_cnt  = lat - 1;
      end else if (m_pend && m_cnt > 0) begin
        m_cnt--;
      end
    end
    bus.imem_rvalid = m_pend && (m_cnt == 0);
    bus.imem_rdata  = (m_pend && m_cnt == 0) ? (m_addr ^ KEY) : 32'hDEAD_BEEF;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    mem_step();
  endtask

  // Step until IF_Valid is presented (settled, not yet clocked) or time out.
  task automatic wait_valid(input int max_cyc, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      settle();
      if (IF_Valid) begin
        found = 1'b1;
        break;
      end
      finish_cycle();
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: IF_Valid never rose within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'b0, bus.imem_req}, 32'h1);
    chk({tag, "_addr"},   bus.imem_addr, 32'h0);
    chk({tag, "_valid"},  {31'b0, IF_Valid}, 32'h0);
    chk({tag, "_pc"},     IF_PC, 32'h0);
    chk({tag, "_pc4"},    IF_PCplus4, 32'h0);
    chk({tag, "_instr"},  IF_Instr, NOP_INSTR);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   start_consumed;

    vecs[0]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0};
    for (int i = 6; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 32'hC, 1'b1, 32'h8};
    vecs[11] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
    vecs[12] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0};

    reset_n         = 1'b0;
    IF_IDWrite      = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Free run with a 1-cycle memory, then a 5-cycle stall holding PC 0x8.
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      IF_IDWrite = vecs[i].idw;
      settle();
      chk($sformatf("tbl%0d_req", i),   {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("tbl%0d_addr", i),  bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, IF_Valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("tbl%0d_pc", i),    IF_PC, vecs[i].exp_pc);
      finish_cycle();
    end

    // Redirect in WAIT: 0x10 is granted, redirect next cycle, data 3 later.
    lat = 4;
    IF_IDWrite = 1'b1;
    settle();
    chk("rw_pc_c", IF_PC, 32'hC);
    chk("rw_addr_10", bus.imem_addr, 32'h10);
    finish_cycle();
    lat = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    settle();
    finish_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rw_drain_req", {31'b0, bus.imem_req}, 32'h0);
      chk("rw_drain_valid", {31'b0, IF_Valid}, 32'h0);
      finish_cycle();
    end
    settle();
    chk("rw_req_100", {31'b0, bus.imem_req}, 32'h1);
    chk("rw_addr_100", bus.imem_addr, 32'h100);
    wait_valid(10, "rw_wait");
    chk("rw_pc_100", IF_PC, 32'h100);
    finish_cycle();

    // Redirect coincident with rvalid of 0x104.
    settle();
    chk("rc_rvalid", {31'b0, bus.imem_rvalid}, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    finish_cycle();
    redirect = 1'b0;
    settle();
    chk("rc_req", {31'b0, bus.imem_req}, 32'h1);
    chk("rc_addr_200", bus.imem_addr, 32'h200);
    wait_valid(10, "rc_wait");
    chk("rc_pc_200", IF_PC, 32'h200);

    // Back-pressured memory: grant withheld for 4 further cycles.
    bus.imem_gnt = 1'b0;
    finish_cycle();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_req", {31'b0, bus.imem_req}, 32'h1);
      chk("bp_addr", bus.imem_addr, 32'h204);
      finish_cycle();
    end
    bus.imem_gnt = 1'b1;
    wait_valid(10, "bp_wait");
    chk("bp_pc_204", IF_PC, 32'h204);

    // Wrap: redirect to the top word (low bits set, must be ignored).
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    finish_cycle();
    redirect = 1'b0;
    wait_valid(10, "wrap_wait1");
    chk("wrap_pc_top", IF_PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", IF_PCplus4, 32'h0);
    finish_cycle();
    wait_valid(10, "wrap_wait2");
    chk("wrap_pc_0", IF_PC, 32'h0);

    // Reset asserted while waiting on a slow response.
    lat = 5;
    finish_cycle();
    settle();
    chk("rst_in_wait_req", {31'b0, bus.imem_req}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    finish_cycle();
    finish_cycle();
    reset_n = 1'b1;
    lat = 1;
    wait_valid(10, "rst_wait_after");
    chk("rst_first_pc", IF_PC, 32'h0);
    finish_cycle();

    // Randomized run: random stalls, grant gaps, latencies and redirects.
    start_consumed = consumed;
    for (int i = 0; i < 3000; i++) begin
      IF_IDWrite   = ($urandom_range(0, 3) != 0);
      bus.imem_gnt = ($urandom_range(0, 2) != 0);
      redirect     = ($urandom_range(0, 15) == 0);
      redirect_pc  = ($urandom_range(0, 1) == 0) ? $urandom : {24'b0, 8'($urandom)};
      lat          = $urandom_range(1, 3);
      finish_cycle();
    end
    redirect = 1'b0;
    n_chk++;
    if (consumed - start_consumed < 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d instructions, expected at least 100",
               consumed - start_consumed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
